// File: rtl/dmem_pipelined_if.sv
// rtl/dmem_pipelined_if.sv - packet types and request/response bus for dmem_pipelined
//
// dmem_pipelined_pkg : opcodes plus instruction_t / writeback_packet_t
// dmem_pipelined_if  : dmem_req_rdy, dmem_req_packet, dmem_rec_rdy,
//                      dmem_rec_packet, dmem_err
//   master - the pipeline issuing requests and consuming responses
//   slave  - the data memory
package dmem_pipelined_pkg;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef struct packed {
        logic        is_valid;
        logic [31:0] data;
    } operand_t;

    typedef struct packed {
        logic        is_valid;
        logic [6:0]  opcode;
        operand_t    src_0_a;
        operand_t    src_1_b;
        logic [7:0]  uop_0;
        logic [5:0]  dest_tag;
    } instruction_t;

    typedef struct packed {
        logic        is_valid;
        logic [31:0] result;
        logic [5:0]  dest_tag;
        logic        exception;
    } writeback_packet_t;
endpackage

interface dmem_pipelined_if;
    import dmem_pipelined_pkg::*;

    logic              dmem_req_rdy;
    instruction_t      dmem_req_packet;
    logic              dmem_rec_rdy;
    writeback_packet_t dmem_rec_packet;
    logic              dmem_err;

    modport master (
        input  dmem_req_rdy,
        output dmem_req_packet,
        output dmem_rec_rdy,
        input  dmem_rec_packet,
        input  dmem_err
    );

    modport slave (
        output dmem_req_rdy,
        input  dmem_req_packet,
        input  dmem_rec_rdy,
        output dmem_rec_packet,
        output dmem_err
    );
endinterface

// File: rtl/dmem_pipelined.sv
// rtl/dmem_pipelined.sv - word-organised data memory with fixed-latency load pipeline
//
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - dmem_pipelined_if.slave: request (rdy/packet), response
//          (rdy/packet) and one-cycle misalignment error pulse
// Stores write at the acceptance edge. Loads read at the acceptance edge,
// travel LATENCY stages and land in an in-order response FIFO. A credit
// counter covers pipeline plus FIFO so the FIFO can never overflow.
module dmem_pipelined
    import dmem_pipelined_pkg::*;
#(
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 2,
    parameter int RESP_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    dmem_pipelined_if.slave bus
);
    localparam int AW         = $clog2(MEM_WORDS);
    localparam int PW         = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int FIFO_SLOTS = 1 << PW;
    localparam int CW         = $clog2(RESP_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    logic [31:0] mem [MEM_WORDS];

    // ---------------- request decode ----------------
    instruction_t req;
    logic [31:0]  addr;
    logic [31:0]  store_data;
    logic [2:0]   funct3;
    logic [1:0]   boff;
    logic [AW-1:0] widx;
    logic         unused_req_bits;

    assign req        = bus.dmem_req_packet;
    assign addr       = req.src_0_a.data;
    assign store_data = req.src_1_b.data;
    assign funct3     = req.uop_0[2:0];
    assign boff       = addr[1:0];
    assign widx       = addr[AW+1:2];   // upper address bits ignored: wraps
    assign unused_req_bits = ^{req};

    logic is_load, is_store, misaligned;
    always_comb begin
        is_load    = (req.opcode == OP_LOAD) &&
                     (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
        is_store   = (req.opcode == OP_STORE) &&
                     ((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W));
        misaligned = 1'b0;
        case (funct3[1:0])
            2'd1:    misaligned = boff[0];
            2'd2:    misaligned = (boff != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // ---------------- credit / acceptance ----------------
    logic [CW-1:0] count;
    logic req_rdy, accept, acc_load, acc_store, pop;

    assign req_rdy   = !rst && (count < DEPTH_C);
    assign accept    = req.is_valid && req_rdy;
    // Misaligned loads still take a credit: they return a zero response.
    assign acc_load  = accept && is_load;
    assign acc_store = accept && is_store && !misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({acc_load, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- store lane steering ----------------
    logic [3:0]  be;
    logic [31:0] wlane;
    always_comb begin
        be    = 4'b0000;
        wlane = store_data;
        case (funct3[1:0])
            2'd0: begin
                be    = 4'b0001 << boff;
                wlane = {4{store_data[7:0]}};
            end
            2'd1: begin
                be    = boff[1] ? 4'b1100 : 4'b0011;
                wlane = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = store_data;
            end
        endcase
    end

    // ---------------- memory and load pipeline ----------------
    logic [LATENCY-1:0] st_valid;
    logic [31:0]        st_data [LATENCY];
    logic [1:0]         st_off  [LATENCY];
    logic [2:0]         st_f3   [LATENCY];
    logic [5:0]         st_tag  [LATENCY];

    always_ff @(posedge clk) begin
        if (acc_store) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[widx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
        if (acc_load) begin
            st_data[0] <= misaligned ? 32'd0 : mem[widx];
            st_off[0]  <= boff;
            st_f3[0]   <= funct3;
            st_tag[0]  <= req.dest_tag;
        end
        for (int i = 1; i < LATENCY; i++) begin
            st_data[i] <= st_data[i-1];
            st_off[i]  <= st_off[i-1];
            st_f3[i]   <= st_f3[i-1];
            st_tag[i]  <= st_tag[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_valid <= '0;
        end else begin
            st_valid[0] <= acc_load;
            for (int i = 1; i < LATENCY; i++) begin
                st_valid[i] <= st_valid[i-1];
            end
        end
    end

    // Extend/extract on the way into the FIFO so the FIFO holds final results.
    logic [31:0] last_word, fmt;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    always_comb begin
        last_word = st_data[LATENCY-1];
        sel_byte  = last_word[{st_off[LATENCY-1], 3'b000} +: 8];
        sel_half  = st_off[LATENCY-1][1] ? last_word[31:16] : last_word[15:0];
        case (st_f3[LATENCY-1])
            F3_B:    fmt = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    fmt = {{16{sel_half[15]}}, sel_half};
            F3_BU:   fmt = {24'd0, sel_byte};
            F3_HU:   fmt = {16'd0, sel_half};
            default: fmt = last_word;
        endcase
    end

    // ---------------- response FIFO ----------------
    logic [31:0] fifo_res [FIFO_SLOTS];
    logic [5:0]  fifo_tag [FIFO_SLOTS];
    logic [PW:0] wr_ptr, rd_ptr;
    logic        push, fifo_empty, rec_valid;

    assign push       = st_valid[LATENCY-1];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign rec_valid  = !rst && !fifo_empty;
    assign pop        = rec_valid && bus.dmem_rec_rdy;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_res[wr_ptr[PW-1:0]] <= fmt;
            fifo_tag[wr_ptr[PW-1:0]] <= st_tag[LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
        end
    end

    // ---------------- error pulse ----------------
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && (is_load || is_store) && misaligned;
        end
    end

    // ---------------- outputs ----------------
    writeback_packet_t rec_pkt;
    always_comb begin
        rec_pkt          = '0;
        rec_pkt.is_valid = rec_valid;
        rec_pkt.result   = fifo_res[rd_ptr[PW-1:0]];
        rec_pkt.dest_tag = fifo_tag[rd_ptr[PW-1:0]];
    end

    assign bus.dmem_req_rdy    = req_rdy;
    assign bus.dmem_rec_packet = rec_pkt;
    assign bus.dmem_err        = err_q && !rst;
endmodule

// File: tb/tb_dmem_pipelined.sv
// tb/tb_dmem_pipelined.sv - self-checking bench for dmem_pipelined
module tb_dmem_pipelined;
    import dmem_pipelined_pkg::*;

    localparam int MEM_WORDS  = 256;
    localparam int LATENCY    = 2;
    localparam int RESP_DEPTH = 4;
    localparam int BYTES      = MEM_WORDS * 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_pipelined_if bus ();

    dmem_pipelined #(
        .MEM_WORDS (MEM_WORDS),
        .LATENCY   (LATENCY),
        .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: byte-addressed memory and a queue of promised responses.
    typedef struct {
        logic [31:0] result;
        logic [5:0]  tag;
        int          ready_cyc;
    } exp_resp_t;
    exp_resp_t  exp_q[$];
    logic [7:0] ref_mem [BYTES];
    logic       ref_err = 1'b0;

    typedef struct {
        logic [31:0] result;
        logic [5:0]  tag;
        int          cyc;
    } obs_t;
    obs_t pops[$];
    logic last_err;
    logic last_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
        return (a % acc_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int base;
        logic [31:0] v;
        base = int'(a % BYTES);
        v = 32'd0;
        for (int k = 0; k < acc_size(f3); k++) v[8*k +: 8] = ref_mem[base + k];
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int base;
        base = int'(a % BYTES);
        for (int k = 0; k < acc_size(f3); k++) ref_mem[base + k] = d[8*k +: 8];
    endtask

    task automatic drive(input bit v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [5:0] tag);
        instruction_t p;
        p = '0;
        p.is_valid         = v;
        p.opcode           = op;
        p.uop_0            = {5'd0, f3};
        p.src_0_a.is_valid = 1'b1;
        p.src_0_a.data     = a;
        p.src_1_b.is_valid = 1'b1;
        p.src_1_b.data     = d;
        p.dest_tag         = tag;
        bus.dmem_req_packet = p;
    endtask

    task automatic idle();
        drive(1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 6'd0);
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic tick();
        bit exp_rdy, exp_valid, acc, pop_e, in_rst;
        instruction_t r;
        logic [2:0] f3;
        logic [31:0] a;
        @(negedge clk);
        r = bus.dmem_req_packet;
        in_rst    = rst;
        exp_rdy   = !in_rst && (exp_q.size() < RESP_DEPTH);
        exp_valid = !in_rst && (exp_q.size() > 0) && (exp_q[0].ready_cyc <= cyc);
        chk("req_rdy", 32'(bus.dmem_req_rdy), 32'(exp_rdy));
        chk("rec_valid", 32'(bus.dmem_rec_packet.is_valid), 32'(exp_valid));
        chk("err", 32'(bus.dmem_err), in_rst ? 32'd0 : 32'(ref_err));
        if (exp_valid && bus.dmem_rec_packet.is_valid) begin
            chk("rec_result", bus.dmem_rec_packet.result, exp_q[0].result);
            chk("rec_tag", 32'(bus.dmem_rec_packet.dest_tag), 32'(exp_q[0].tag));
        end
        last_err = bus.dmem_err;
        last_rdy = bus.dmem_req_rdy;
        if (bus.dmem_rec_packet.is_valid && bus.dmem_rec_rdy)
            pops.push_back('{bus.dmem_rec_packet.result, bus.dmem_rec_packet.dest_tag, cyc});
        acc   = r.is_valid && exp_rdy;
        pop_e = exp_valid && bus.dmem_rec_rdy;
        @(posedge clk);
        cyc++;
        if (in_rst) begin
            exp_q.delete();
            ref_err = 1'b0;
        end else begin
            if (pop_e) void'(exp_q.pop_front());
            ref_err = 1'b0;
            if (acc) begin
                f3 = r.uop_0[2:0];
                a  = r.src_0_a.data;
                if (r.opcode == OP_LOAD && f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) begin
                    exp_q.push_back('{is_mis(f3, a) ? 32'd0 : ref_load(f3, a), r.dest_tag, cyc + LATENCY});
                    ref_err = is_mis(f3, a);
                end else if (r.opcode == OP_STORE && f3 <= 3'd2) begin
                    ref_err = is_mis(f3, a);
                    if (!is_mis(f3, a)) ref_store(f3, a, r.src_1_b.data);
                end
            end
        end
        #1;
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [5:0]  tag;
        bit          resp;
        logic [31:0] exp_res;
        bit          exp_err;
    } vec_t;
    vec_t vt[$];

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, acc_cnt, a0;
        logic [31:0] stall_addr [6];
        logic [31:0] stall_exp  [6];
        logic [31:0] ra;

        vt.push_back('{OP_STORE, 3'd2, 32'h04, 32'hDEADBEEF, 6'd0,  1'b0, 32'h0,        1'b0});
        vt.push_back('{OP_LOAD,  3'd2, 32'h04, 32'h0,        6'd5,  1'b1, 32'hDEADBEEF, 1'b0});
        vt.push_back('{OP_STORE, 3'd1, 32'h08, 32'hAAAAAAAA, 6'd0,  1'b0, 32'h0,        1'b0});
        vt.push_back('{OP_LOAD,  3'd1, 32'h08, 32'h0,        6'd1,  1'b1, 32'hFFFFAAAA, 1'b0});
        vt.push_back('{OP_LOAD,  3'd4, 32'h08, 32'h0,        6'd2,  1'b1, 32'h000000AA, 1'b0});
        vt.push_back('{OP_LOAD,  3'd0, 32'h09, 32'h0,        6'd3,  1'b1, 32'hFFFFFFAA, 1'b0});
        vt.push_back('{OP_LOAD,  3'd2, 32'h06, 32'h0,        6'd3,  1'b1, 32'h0,        1'b1});
        vt.push_back('{OP_STORE, 3'd2, 32'h02, 32'h11111111, 6'd0,  1'b0, 32'h0,        1'b1});
        vt.push_back('{OP_LOAD,  3'd2, 32'h00, 32'h0,        6'd7,  1'b1, 32'h5A5A0000, 1'b0});
        vt.push_back('{OP_STORE, 3'd2, 32'h400, 32'h12345678, 6'd0, 1'b0, 32'h0,        1'b0});
        vt.push_back('{OP_LOAD,  3'd2, 32'h000, 32'h0,       6'd9,  1'b1, 32'h12345678, 1'b0});
        vt.push_back('{OP_STORE, 3'd2, 32'h10, 32'h80C0FFEE, 6'd0,  1'b0, 32'h0,        1'b0});
        vt.push_back('{OP_LOAD,  3'd5, 32'h12, 32'h0,        6'd10, 1'b1, 32'h000080C0, 1'b0});
        vt.push_back('{OP_LOAD,  3'd1, 32'h12, 32'h0,        6'd11, 1'b1, 32'hFFFF80C0, 1'b0});
        vt.push_back('{OP_LOAD,  3'd0, 32'h13, 32'h0,        6'd12, 1'b1, 32'hFFFFFF80, 1'b0});
        vt.push_back('{OP_LOAD,  3'd4, 32'h10, 32'h0,        6'd13, 1'b1, 32'h000000EE, 1'b0});
        vt.push_back('{OP_STORE, 3'd0, 32'h11, 32'h0000007F, 6'd0,  1'b0, 32'h0,        1'b0});
        vt.push_back('{OP_LOAD,  3'd2, 32'h10, 32'h0,        6'd14, 1'b1, 32'h80C07FEE, 1'b0});
        vt.push_back('{7'h33,    3'd2, 32'h10, 32'h0,        6'd0,  1'b0, 32'h0,        1'b0});
        vt.push_back('{OP_STORE, 3'd3, 32'h10, 32'h0,        6'd0,  1'b0, 32'h0,        1'b0});
        vt.push_back('{OP_LOAD,  3'd6, 32'h10, 32'h0,        6'd15, 1'b0, 32'h0,        1'b0});
        vt.push_back('{OP_STORE, 3'd1, 32'h11, 32'h0,        6'd0,  1'b0, 32'h0,        1'b1});
        vt.push_back('{OP_LOAD,  3'd2, 32'h10, 32'h0,        6'd16, 1'b1, 32'h80C07FEE, 1'b0});
        vt.push_back('{OP_LOAD,  3'd1, 32'h0E, 32'h0,        6'd17, 1'b1, 32'h00005959, 1'b0});
        vt.push_back('{OP_LOAD,  3'd2, 32'hFFFFFC04, 32'h0,  6'd18, 1'b1, 32'hDEADBEEF, 1'b0});
        vt.push_back('{OP_LOAD,  3'd1, 32'h03, 32'h0,        6'd19, 1'b1, 32'h0,        1'b1});

        // ---- reset ----
        idle();
        bus.dmem_rec_rdy = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("reset_rdy", 32'(last_rdy), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_reset_rdy", 32'(last_rdy), 32'd1);

        // ---- fill memory with a known pattern ----
        for (int i = 0; i < MEM_WORDS; i++) begin
            drive(1'b1, OP_STORE, 3'd2, 32'(i * 4), init_word(i), 6'd0);
            tick();
        end
        idle();
        tick();

        // ---- directed vectors, one at a time ----
        for (int i = 0; i < vt.size(); i++) begin
            pops.delete();
            drive(1'b1, vt[i].op, vt[i].f3, vt[i].addr, vt[i].data, vt[i].tag);
            a0 = cyc + 1;
            tick();
            idle();
            tick();
            chk($sformatf("vec%0d_err", i), 32'(last_err), 32'(vt[i].exp_err));
            for (int k = 0; k < 6; k++) tick();
            chk($sformatf("vec%0d_nresp", i), pops.size(), vt[i].resp ? 32'd1 : 32'd0);
            if (vt[i].resp && pops.size() == 1) begin
                chk($sformatf("vec%0d_result", i), pops[0].result, vt[i].exp_res);
                chk($sformatf("vec%0d_tag", i), 32'(pops[0].tag), 32'(vt[i].tag));
                chk($sformatf("vec%0d_latency", i), pops[0].cyc - a0, LATENCY);
            end
        end

        // ---- back-to-back loads return in issue order ----
        pops.delete();
        drive(1'b1, OP_LOAD, 3'd1, 32'h08, 32'h0, 6'd1); tick();
        drive(1'b1, OP_LOAD, 3'd4, 32'h08, 32'h0, 6'd2); tick();
        drive(1'b1, OP_LOAD, 3'd0, 32'h09, 32'h0, 6'd3); tick();
        idle();
        for (int k = 0; k < 8; k++) tick();
        chk("order_n", pops.size(), 3);
        if (pops.size() == 3) begin
            chk("order_r0", pops[0].result, 32'hFFFFAAAA);
            chk("order_r1", pops[1].result, 32'h000000AA);
            chk("order_r2", pops[2].result, 32'hFFFFFFAA);
            chk("order_t2", 32'(pops[2].tag), 32'd3);
        end

        // ---- credit exhaustion under back-pressure ----
        stall_addr = '{32'h04, 32'h10, 32'h00, 32'h0C, 32'h08, 32'h14};
        stall_exp  = '{32'hDEADBEEF, 32'h80C07FEE, 32'h12345678,
                       32'h59590303, 32'h5858AAAA, 32'h5F5F0505};
        pops.delete();
        bus.dmem_rec_rdy = 1'b0;
        idx = 0;
        acc_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (idx < 6) drive(1'b1, OP_LOAD, 3'd2, stall_addr[idx], 32'h0, 6'(20 + idx));
            else idle();
            tick();
            if (last_rdy && idx < 6) begin
                idx++;
                acc_cnt++;
            end
        end
        chk("stall_accepted", acc_cnt, 4);
        chk("stall_rdy_low", 32'(last_rdy), 32'd0);
        bus.dmem_rec_rdy = 1'b1;
        for (int k = 0; k < 40 && pops.size() < 6; k++) begin
            if (idx < 6) drive(1'b1, OP_LOAD, 3'd2, stall_addr[idx], 32'h0, 6'(20 + idx));
            else idle();
            tick();
            if (last_rdy && idx < 6) idx++;
        end
        idle();
        chk("stall_nresp", pops.size(), 6);
        for (int k = 0; k < 6 && k < pops.size(); k++) begin
            chk($sformatf("stall_tag%0d", k), 32'(pops[k].tag), 32'(20 + k));
            chk($sformatf("stall_res%0d", k), pops[k].result, stall_exp[k]);
        end

        // ---- reset with loads in flight ----
        pops.delete();
        drive(1'b1, OP_LOAD, 3'd2, 32'h04, 32'h0, 6'd30); tick();
        drive(1'b1, OP_LOAD, 3'd2, 32'h10, 32'h0, 6'd31); tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_release_rdy", 32'(last_rdy), 32'd1);
        for (int k = 0; k < 6; k++) tick();
        chk("rst_no_resp", pops.size(), 0);
        drive(1'b1, OP_LOAD, 3'd2, 32'h04, 32'h0, 6'd32); tick();
        idle();
        for (int k = 0; k < 6; k++) tick();
        chk("rst_mem_kept_n", pops.size(), 1);
        if (pops.size() == 1) chk("rst_mem_kept", pops[0].result, 32'hDEADBEEF);

        // ---- randomized traffic against the model ----
        for (int k = 0; k < 600; k++) begin
            int kind;
            logic [2:0] f3;
            kind = $urandom_range(0, 9);
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            bus.dmem_rec_rdy = ($urandom_range(0, 3) != 0);
            if (kind < 5) begin
                f3 = 3'($urandom_range(0, 7));
                drive($urandom_range(0, 3) != 0, OP_LOAD, f3, ra, 32'h0, 6'($urandom));
            end else if (kind < 9) begin
                case ($urandom_range(0, 5))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd3;
                    4: f3 = 3'd6;
                    default: f3 = 3'd7;
                endcase
                drive($urandom_range(0, 3) != 0, OP_STORE, f3, ra, $urandom, 6'($urandom));
            end else begin
                drive(1'b1, 7'h13, 3'd2, ra, $urandom, 6'($urandom));
            end
            tick();
        end
        idle();
        bus.dmem_rec_rdy = 1'b1;
        for (int k = 0; k < 12; k++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
